mux_rr_n_a_1: RTL

- Parametrised N-to-1 registered multiplexer. It is the successor of the team's combinational 4-to-1 data mux.
- Each input channel has a valid/ready handshake, and the output has a single registered stage.
- Two selection modes:
  - Fixed: the channel is chosen by i_sel.
  - Round-robin: fair arbitration among the channels that are presenting valid data.
- Sits between several producers and one shared consumer, for example a shared UART/PWM data path.

---
 rtl/mux_rr_n_a_1.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux_rr_n_a_1.sv
// mux_rr_n_a_1: N-to-1 registered mux with per-channel valid/ready handshake.
// Channels are picked either by a fixed selector or by a round-robin arbiter.
// The single output register accepts a new word whenever it is empty or
// being drained in the same cycle, so i_listo=1 gives one word per cycle.

// Per-channel grant cell: decides whether this channel wins the current load.
module mux_rr_n_a_1_canal #(
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int K     = 0
) (
    input  logic [N-1:0]     valido_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             modo_i,
    input  logic             carga_i,
    output logic             grant_o,
    output logic             listo_o
);
    int dk;

    // Round-robin: win if valid and no valid channel sits closer after ptr.
    always_comb begin
        dk      = 0;
        grant_o = 1'b0;
        if (!modo_i) begin
            // A selector >= N matches no channel, so it never grants.
            grant_o = valido_i[K] && (int'(sel_i) == K);
        end else begin
            dk      = (K + 2*N - int'(ptr_i) - 1) % N;
            grant_o = valido_i[K];
            for (int j = 0; j < N; j++) begin
                if (j != K && valido_i[j] &&
                    ((j + 2*N - int'(ptr_i) - 1) % N) < dk)
                    grant_o = 1'b0;
            end
        end
    end

    assign listo_o = carga_i & grant_o;
endmodule

module mux_rr_n_a_1 #(
    parameter  int N_CANALES = 4,
    parameter  int ANCHO     = 4,
    localparam int SEL_W     = $clog2(N_CANALES)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_CANALES*ANCHO-1:0]   i_Datos,
    input  logic [N_CANALES-1:0]         i_valido,
    output logic [N_CANALES-1:0]         o_listo,
    input  logic                         i_modo,
    input  logic [SEL_W-1:0]             i_sel,
    output logic [ANCHO-1:0]             o_datos,
    output logic                         o_valido,
    input  logic                         i_listo,
    output logic [SEL_W-1:0]             o_canal
);
    logic [ANCHO-1:0]     datos_q, datos_d;
    logic [SEL_W-1:0]     canal_q, canal_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic                 valido_q, valido_d;
    logic                 carga;
    logic                 carga_ok;
    logic [N_CANALES-1:0] grant;

    assign carga    = ~valido_q | i_listo;
    // Ready is forced low while reset is held, even though the register is empty.
    assign carga_ok = carga & i_rst_n;

    for (genvar k = 0; k < N_CANALES; k++) begin : g_canal
        mux_rr_n_a_1_canal #(
            .N     (N_CANALES),
            .SEL_W (SEL_W),
            .K     (k)
        ) u_canal (
            .valido_i (i_valido),
            .ptr_i    (ptr_q),
            .sel_i    (i_sel),
            .modo_i   (i_modo),
            .carga_i  (carga_ok),
            .grant_o  (grant[k]),
            .listo_o  (o_listo[k])
        );
    end

    // Next state of the output stage: load the granted word or go empty.
    always_comb begin
        datos_d  = datos_q;
        canal_d  = canal_q;
        valido_d = valido_q;
        ptr_d    = ptr_q;
        if (carga) begin
            valido_d = |grant;
            for (int k = 0; k < N_CANALES; k++) begin
                if (grant[k]) begin
                    datos_d = i_Datos[k*ANCHO +: ANCHO];
                    canal_d = SEL_W'(k);
                    if (i_modo)
                        ptr_d = SEL_W'(k);
                end
            end
        end
    end

    // Output register and round-robin pointer; ptr resets so channel 0 goes first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            datos_q  <= '0;
            canal_q  <= '0;
            valido_q <= 1'b0;
            ptr_q    <= SEL_W'(N_CANALES - 1);
        end else begin
            datos_q  <= datos_d;
            canal_q  <= canal_d;
            valido_q <= valido_d;
            ptr_q    <= ptr_d;
        end
    end

    assign o_datos  = datos_q;
    assign o_canal  = canal_q;
    assign o_valido = valido_q;
endmodule
